fetch_stage: RTL and testbench

Instruction fetch stage of the single-issue pipeline: owns the architectural PC register and the IF/ID pipeline register. It issues instruction-memory requests over a valid/ready-style handshake and advances the PC by 2 on each accepted instruction. It takes redirects from the branch-resolution logic downstream, which supplies `redirect` and the computed `redirect_target`. It detects the HLT opcode and freezes the PC on the halt instruction.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID register, issues imem
// requests, follows redirects, and parks on an HLT opcode until redirected.
module fetch_stage #(
    parameter logic [3:0]  HLT_OPC  = 4'hF,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        halted
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus2;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] accept_word;
    logic            accept;

    assign pc_plus2 = pc + XLEN'(2);

    // Request is decoded from state; forced low while reset is asserted.
    assign imem_req  = rst_n && ((state == FETCH) || (state == DRAIN));
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    // An instruction enters IF/ID either straight from memory or from the hold buffer.
    always_comb begin
        accept      = 1'b0;
        accept_word = imem_data;
        case (state)
            FETCH: accept = imem_valid && !stall;
            HOLD: begin
                accept      = !stall;
                accept_word = hold_instr;
            end
            default: accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            drain_addr    <= '0;
            hold_instr    <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus2 <= '0;
            halted        <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_target & ~XLEN'(1);
            ifid_valid <= 1'b0;
            hold_instr <= '0;
            halted     <= 1'b0;
            // An unanswered request must be drained before fetching the target.
            if (state == FETCH && !imem_valid) begin
                drain_addr <= pc;
                state      <= DRAIN;
            end else if (state == DRAIN && !imem_valid) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid && stall) begin
                        hold_instr <= imem_data;
                        state      <= HOLD;
                    end else if (!imem_valid && !stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                DRAIN: if (imem_valid) state <= FETCH;
                HALT:  if (!stall) ifid_valid <= 1'b0;
                default: ;
            endcase

            if (accept) begin
                ifid_valid    <= 1'b1;
                ifid_instr    <= accept_word;
                ifid_pc       <= pc;
                ifid_pc_plus2 <= pc_plus2;
                // HLT parks the PC on its own address.
                if (accept_word[15:12] == HLT_OPC) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    pc    <= pc_plus2;
                    state <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-by-cycle vector table plus an
// asynchronous reset applied mid-HOLD.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        stall;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        halted;

    int total;
    int bad;

    fetch_stage #(.HLT_OPC(4'hF), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .imem_valid      (imem_valid),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stall           (stall),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus2   (ifid_pc_plus2),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] tgt;
        logic        st;
        logic        vld;
        logic [15:0] data;
        logic        e_iv;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic [15:0] e_p2;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_hlt;
    } vec_t;

    localparam int unsigned NVEC = 20;
    vec_t vecs [NVEC];

    function automatic logic [66:0] observed();
        return {ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus2, imem_req, imem_addr, halted};
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got iv/instr/pc/p2/req/addr/hlt=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //                rd  tgt       st  vld data      iv  instr     pc        p2        req addr      hlt
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 16'h0000, 16'h0002, 1'b1, 16'h0002, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2345, 1'b1, 16'h2345, 16'h0002, 16'h0004, 1'b1, 16'h0004, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h3456, 1'b1, 16'h2345, 16'h0002, 16'h0004, 1'b0, 16'h0004, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2345, 16'h0002, 16'h0004, 1'b0, 16'h0004, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2345, 16'h0002, 16'h0004, 1'b0, 16'h0004, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3456, 16'h0004, 16'h0006, 1'b1, 16'h0006, 1'b0};
        vecs[6]  = '{1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h3456, 16'h0004, 16'h0006, 1'b1, 16'h0006, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h3456, 16'h0004, 16'h0006, 1'b1, 16'h0006, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h3456, 16'h0004, 16'h0006, 1'b1, 16'h0040, 1'b0};
        vecs[9]  = '{1'b1, 16'h0008, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h3456, 16'h0004, 16'h0006, 1'b1, 16'h0008, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hF000, 1'b1, 16'hF000, 16'h0008, 16'h000A, 1'b0, 16'h0008, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0008, 16'h000A, 1'b0, 16'h0008, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0008, 16'h000A, 1'b0, 16'h0008, 1'b1};
        vecs[13] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0008, 16'h000A, 1'b1, 16'h0010, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111, 1'b1, 16'h1111, 16'h0010, 16'h0012, 1'b1, 16'h0012, 1'b0};
        vecs[15] = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1111, 16'h0010, 16'h0012, 1'b1, 16'h0012, 1'b0};
        vecs[16] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1111, 16'h0010, 16'h0012, 1'b1, 16'h0012, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5555, 1'b0, 16'h1111, 16'h0010, 16'h0012, 1'b1, 16'hFFFE, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b1, 16'h2222, 16'hFFFE, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333, 1'b1, 16'h2222, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 1'b0};

        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        stall           = 1'b0;
        imem_valid      = 1'b0;
        imem_data       = 16'h0000;

        #12;
        check("reset_state", observed(), 67'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_req", observed(), {1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0});

        for (int i = 0; i < int'(NVEC); i++) begin
            redirect        = vecs[i].rd;
            redirect_target = vecs[i].tgt;
            stall           = vecs[i].st;
            imem_valid      = vecs[i].vld;
            imem_data       = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), observed(),
                  {vecs[i].e_iv, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_p2,
                   vecs[i].e_req, vecs[i].e_addr, vecs[i].e_hlt});
        end

        // Asynchronous reset between edges while parked in HOLD.
        redirect   = 1'b0;
        stall      = 1'b1;
        imem_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_hold", observed(), 67'd0);
        rst_n = 1'b1;
        stall = 1'b0;
        #1;
        check("restart_req", observed(), {1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0});
        imem_valid = 1'b1;
        imem_data  = 16'h4444;
        @(posedge clk);
        #1;
        check("restart_fetch", observed(), {1'b1, 16'h4444, 16'h0000, 16'h0002, 1'b1, 16'h0002, 1'b0});
        imem_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
